// File: rtl/main_control_fsm.sv
// -----------------------------------------------------------------------------
// main_control_fsm
//
// Multicycle main control unit for the F_cpu datapath. The FSM decodes OPCODE
// and funct from the IR. It sequences the datapath load enables and the mux
// selects for PC, Memoria, IR, MDR, A/B, ALUOut, EPC and Banco_reg.
//
// Supported instructions: add, sub, and, slt, jr, addi, lw, sw, beq, bne, j.
// An invalid opcode or R-type funct raises exception vector 253. An overflow
// on add, sub or addi raises exception vector 254. For both exceptions the
// unit saves PC-4 into EPC, reads the handler address from the memory vector
// table, and jumps there.
//
// All outputs are Moore outputs decoded from the current state. The one
// exception is PC_write in BRANCH, which follows the ALU zero flag.
//
// Parameters
//   MEM_WAIT            number of cycles a Memoria read address is held
//                       before the data is consumed (>= 1)
//
// Ports
//   clk                 system clock, rising edge
//   reset               asynchronous reset, active low
//   OPCODE              IR[31:26]
//   funct               IR[5:0]
//   Overflow, zero      ula32 status flags (combinational)
//   PC_write .. RegWrite  load enables, active high
//   MEMRead             0 = read, 1 = write
//   IorD                memory address select (PC/A/B/ALUOut/253/254)
//   ALUSourceA/B        ALU operand selects
//   ALU_control         ula32 operation
//   RegDst, MenToReg    register-file write address / data selects
//   PCSource            next-PC select
//   load_size_control   load size (word/half/byte)
//   store_control_sign  store size (word/half/byte)
//   state_out           current state encoding
// -----------------------------------------------------------------------------
module main_control_fsm #(
    parameter int MEM_WAIT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OPCODE,
    input  logic [5:0] funct,
    input  logic       Overflow,
    input  logic       zero,
    output logic       PC_write,
    output logic       IRWrite,
    output logic       MDR_load,
    output logic       A_load,
    output logic       B_load,
    output logic       AluOutWrite,
    output logic       EPCWrite,
    output logic       RegWrite,
    output logic       MEMRead,
    output logic [2:0] IorD,
    output logic [1:0] ALUSourceA,
    output logic [2:0] ALUSourceB,
    output logic [2:0] ALU_control,
    output logic [1:0] RegDst,
    output logic [2:0] MenToReg,
    output logic [2:0] PCSource,
    output logic [1:0] load_size_control,
    output logic [1:0] store_control_sign,
    output logic [4:0] state_out
);

    // Opcodes and R-type functs
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    // ula32 operations
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_CMP  = 3'b111;

    // Mux codes
    localparam logic [2:0] IORD_ALUOUT = 3'd3;
    localparam logic [2:0] IORD_V253   = 3'd4;
    localparam logic [2:0] IORD_V254   = 3'd5;
    localparam logic [1:0] SRCA_PC     = 2'd0;
    localparam logic [1:0] SRCA_A      = 2'd1;
    localparam logic [2:0] SRCB_B      = 3'd0;
    localparam logic [2:0] SRCB_4      = 3'd1;
    localparam logic [2:0] SRCB_SE16   = 3'd2;
    localparam logic [2:0] SRCB_SL2    = 3'd3;
    localparam logic [1:0] DST_RT      = 2'd0;
    localparam logic [1:0] DST_RD      = 2'd1;
    localparam logic [2:0] M2R_ALUOUT  = 3'd0;
    localparam logic [2:0] M2R_LT      = 3'd1;
    localparam logic [2:0] M2R_LS      = 3'd2;
    localparam logic [2:0] PCS_ALU     = 3'd0;
    localparam logic [2:0] PCS_ALUOUT  = 3'd1;
    localparam logic [2:0] PCS_JUMP    = 3'd3;
    localparam logic [2:0] PCS_LS      = 3'd4;
    localparam logic [2:0] PCS_A       = 3'd5;
    localparam logic [1:0] SIZE_WORD   = 2'd0;
    localparam logic [1:0] SIZE_BYTE   = 2'd2;

    typedef enum logic [4:0] {
        S_RESET    = 5'd0,
        S_FETCH    = 5'd1,
        S_FETCH_WB = 5'd2,
        S_DECODE   = 5'd3,
        S_R_EXEC   = 5'd4,
        S_R_WB     = 5'd5,
        S_JR       = 5'd6,
        S_J        = 5'd7,
        S_ADDI     = 5'd8,
        S_ADDI_WB  = 5'd9,
        S_MEM_ADDR = 5'd10,
        S_LW_READ  = 5'd11,
        S_LW_WB    = 5'd12,
        S_SW_WRITE = 5'd13,
        S_BRANCH   = 5'd14,
        S_EXC_EPC  = 5'd15,
        S_EXC_SAVE = 5'd16,
        S_EXC_READ = 5'd17,
        S_EXC_JUMP = 5'd18
    } state_t;

    // The wait counter only ever holds values up to MEM_WAIT-1.
    localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam logic [CW-1:0] LOAD_MEM = CW'(MEM_WAIT - 1);
    // EXC_SAVE already spends one cycle on the vector address, so EXC_READ
    // covers the remaining MEM_WAIT-1 cycles.
    localparam logic [CW-1:0] LOAD_EXC = (MEM_WAIT > 1) ? CW'(MEM_WAIT - 2) : '0;

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   wait_cnt;
    logic            wait_done;
    logic            exc_ovf;      // 1: vector 254 (overflow), 0: vector 253
    logic            r_valid;
    logic            r_arith;

    assign wait_done = (wait_cnt == '0);
    assign state_out = state;

    // Recognised R-type functs, and those that can overflow.
    assign r_valid = (funct == FN_ADD) || (funct == FN_SUB) ||
                     (funct == FN_AND) || (funct == FN_SLT);
    assign r_arith = (funct == FN_ADD) || (funct == FN_SUB);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_RESET;
        end else begin
            state <= next_state;
        end
    end

    // The wait counter reloads whenever a new state is entered, so each
    // multi-cycle memory state starts its own fresh count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (next_state != state) begin
            wait_cnt <= (next_state == S_EXC_READ) ? LOAD_EXC : LOAD_MEM;
        end else if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - CW'(1);
        end
    end

    // The exception cause is only known in DECODE (invalid instruction) or in
    // the execute states (overflow). It is latched here so the later
    // exception states still know which vector to read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exc_ovf <= 1'b0;
        end else if (next_state == S_EXC_EPC) begin
            exc_ovf <= (state != S_DECODE);
        end
    end

    // ------------------------------------------------------------ next state
    always_comb begin
        next_state = state;
        case (state)
            S_RESET:    next_state = S_FETCH;
            S_FETCH:    if (wait_done) next_state = S_FETCH_WB;
            S_FETCH_WB: next_state = S_DECODE;
            S_DECODE: begin
                case (OPCODE)
                    OP_RTYPE: begin
                        if (funct == FN_JR)  next_state = S_JR;
                        else if (r_valid)    next_state = S_R_EXEC;
                        else                 next_state = S_EXC_EPC;
                    end
                    OP_ADDI:        next_state = S_ADDI;
                    OP_LW, OP_SW:   next_state = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: next_state = S_BRANCH;
                    OP_J:           next_state = S_J;
                    default:        next_state = S_EXC_EPC;
                endcase
            end
            S_R_EXEC:   next_state = (Overflow && r_arith) ? S_EXC_EPC : S_R_WB;
            S_ADDI:     next_state = Overflow ? S_EXC_EPC : S_ADDI_WB;
            S_MEM_ADDR: next_state = (OPCODE == OP_SW) ? S_SW_WRITE : S_LW_READ;
            S_LW_READ:  if (wait_done) next_state = S_LW_WB;
            S_EXC_EPC:  next_state = S_EXC_SAVE;
            S_EXC_SAVE: next_state = (MEM_WAIT > 1) ? S_EXC_READ : S_EXC_JUMP;
            S_EXC_READ: if (wait_done) next_state = S_EXC_JUMP;
            S_R_WB, S_JR, S_J, S_ADDI_WB, S_LW_WB, S_SW_WRITE, S_BRANCH,
            S_EXC_JUMP: next_state = S_FETCH;
            default:    next_state = S_RESET;
        endcase
    end

    // --------------------------------------------------------------- outputs
    always_comb begin
        PC_write           = 1'b0;
        IRWrite            = 1'b0;
        MDR_load           = 1'b0;
        A_load             = 1'b0;
        B_load             = 1'b0;
        AluOutWrite        = 1'b0;
        EPCWrite           = 1'b0;
        RegWrite           = 1'b0;
        MEMRead            = 1'b0;
        IorD               = 3'd0;
        ALUSourceA         = 2'd0;
        ALUSourceB         = 3'd0;
        ALU_control        = 3'b000;
        RegDst             = 2'd0;
        MenToReg           = 3'd0;
        PCSource           = 3'd0;
        load_size_control  = 2'd0;
        store_control_sign = 2'd0;

        case (state)
            S_FETCH: begin
                // Memoria addressed by PC (read); ALU precomputes PC+4.
                ALUSourceA  = SRCA_PC;
                ALUSourceB  = SRCB_4;
                ALU_control = ALU_ADD;
            end
            S_FETCH_WB: begin
                IRWrite     = 1'b1;
                PC_write    = 1'b1;
                PCSource    = PCS_ALU;
                ALUSourceA  = SRCA_PC;
                ALUSourceB  = SRCB_4;
                ALU_control = ALU_ADD;
            end
            S_DECODE: begin
                // Branch target computed speculatively while registers load.
                A_load      = 1'b1;
                B_load      = 1'b1;
                ALUSourceA  = SRCA_PC;
                ALUSourceB  = SRCB_SL2;
                ALU_control = ALU_ADD;
                AluOutWrite = 1'b1;
            end
            S_R_EXEC: begin
                ALUSourceA  = SRCA_A;
                ALUSourceB  = SRCB_B;
                AluOutWrite = 1'b1;
                case (funct)
                    FN_ADD:  ALU_control = ALU_ADD;
                    FN_SUB:  ALU_control = ALU_SUB;
                    FN_AND:  ALU_control = ALU_AND;
                    FN_SLT:  ALU_control = ALU_CMP;
                    default: ALU_control = 3'b000;
                endcase
            end
            S_R_WB: begin
                RegDst   = DST_RD;
                RegWrite = 1'b1;
                if (funct == FN_SLT) begin
                    // The less-than flag comes straight from the comparator,
                    // so the ALU must keep comparing during write-back.
                    MenToReg    = M2R_LT;
                    ALUSourceA  = SRCA_A;
                    ALUSourceB  = SRCB_B;
                    ALU_control = ALU_CMP;
                end else begin
                    MenToReg = M2R_ALUOUT;
                end
            end
            S_JR: begin
                PC_write = 1'b1;
                PCSource = PCS_A;
            end
            S_J: begin
                PC_write = 1'b1;
                PCSource = PCS_JUMP;
            end
            S_ADDI, S_MEM_ADDR: begin
                ALUSourceA  = SRCA_A;
                ALUSourceB  = SRCB_SE16;
                ALU_control = ALU_ADD;
                AluOutWrite = 1'b1;
            end
            S_ADDI_WB: begin
                RegDst   = DST_RT;
                MenToReg = M2R_ALUOUT;
                RegWrite = 1'b1;
            end
            S_LW_READ: begin
                IorD = IORD_ALUOUT;
            end
            S_LW_WB: begin
                MDR_load          = 1'b1;
                load_size_control = SIZE_WORD;
                MenToReg          = M2R_LS;
                RegDst            = DST_RT;
                RegWrite          = 1'b1;
            end
            S_SW_WRITE: begin
                IorD               = IORD_ALUOUT;
                MEMRead            = 1'b1;
                store_control_sign = SIZE_WORD;
            end
            S_BRANCH: begin
                ALUSourceA  = SRCA_A;
                ALUSourceB  = SRCB_B;
                ALU_control = ALU_SUB;
                PCSource    = PCS_ALUOUT;
                PC_write    = (OPCODE == OP_BNE) ? ~zero : zero;
            end
            S_EXC_EPC: begin
                // PC has already advanced past the faulting instruction.
                ALUSourceA  = SRCA_PC;
                ALUSourceB  = SRCB_4;
                ALU_control = ALU_SUB;
                AluOutWrite = 1'b1;
            end
            S_EXC_SAVE: begin
                EPCWrite = 1'b1;
                IorD     = exc_ovf ? IORD_V254 : IORD_V253;
            end
            S_EXC_READ: begin
                IorD = exc_ovf ? IORD_V254 : IORD_V253;
            end
            S_EXC_JUMP: begin
                // Handler address is the byte stored at the vector slot.
                load_size_control = SIZE_BYTE;
                PCSource          = PCS_LS;
                PC_write          = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_main_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_main_control_fsm
//
// Directed bench for main_control_fsm. For every cycle of each instruction,
// the driver pushes the hand-written expected state and output vector. A
// monitor pops one entry each falling edge and compares it with the DUT.
// -----------------------------------------------------------------------------
module tb_main_control_fsm;

  localparam int MEM_WAIT = 2;
  localparam int W        = 37;

  localparam logic [4:0] S_RESET = 5'd0,  S_FETCH = 5'd1,  S_FETCH_WB = 5'd2,
                         S_DECODE = 5'd3, S_R_EXEC = 5'd4, S_R_WB = 5'd5,
                         S_JR = 5'd6,     S_J = 5'd7,      S_ADDI = 5'd8,
                         S_ADDI_WB = 5'd9, S_MEM_ADDR = 5'd10, S_LW_READ = 5'd11,
                         S_LW_WB = 5'd12, S_SW_WRITE = 5'd13, S_BRANCH = 5'd14,
                         S_EXC_EPC = 5'd15, S_EXC_SAVE = 5'd16, S_EXC_READ = 5'd17,
                         S_EXC_JUMP = 5'd18;

  typedef struct packed {
    logic [4:0] st;
    logic       pcw, irw, mdr, al, bl, aow, epcw, rw, memr;
    logic [2:0] iord;
    logic [1:0] srca;
    logic [2:0] srcb;
    logic [2:0] aluc;
    logic [1:0] rdst;
    logic [2:0] m2r;
    logic [2:0] pcs;
    logic [1:0] lsc;
    logic [1:0] scs;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [5:0] OPCODE, funct;
  logic       Overflow, zero;
  logic       PC_write, IRWrite, MDR_load, A_load, B_load, AluOutWrite, EPCWrite, RegWrite;
  logic       MEMRead;
  logic [2:0] IorD, ALUSourceB, ALU_control, MenToReg, PCSource;
  logic [1:0] ALUSourceA, RegDst, load_size_control, store_control_sign;
  logic [4:0] state_out;
  logic [W-1:0] dut_vec;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;

  main_control_fsm #(.MEM_WAIT(MEM_WAIT)) dut (
    .clk(clk), .reset(reset), .OPCODE(OPCODE), .funct(funct),
    .Overflow(Overflow), .zero(zero),
    .PC_write(PC_write), .IRWrite(IRWrite), .MDR_load(MDR_load),
    .A_load(A_load), .B_load(B_load), .AluOutWrite(AluOutWrite),
    .EPCWrite(EPCWrite), .RegWrite(RegWrite), .MEMRead(MEMRead),
    .IorD(IorD), .ALUSourceA(ALUSourceA), .ALUSourceB(ALUSourceB),
    .ALU_control(ALU_control), .RegDst(RegDst), .MenToReg(MenToReg),
    .PCSource(PCSource), .load_size_control(load_size_control),
    .store_control_sign(store_control_sign), .state_out(state_out)
  );

  assign dut_vec = {state_out, PC_write, IRWrite, MDR_load, A_load, B_load,
                    AluOutWrite, EPCWrite, RegWrite, MEMRead, IorD, ALUSourceA,
                    ALUSourceB, ALU_control, RegDst, MenToReg, PCSource,
                    load_size_control, store_control_sign};

  // ---------------------------------------------------------- clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------ scoreboard
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string        nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (dut_vec !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h (state got %0d exp %0d)",
                 nm, dut_vec, e, state_out, e[W-1 -: 5]);
      end
      checks++;
      if (RegWrite && MEMRead) begin
        errors++;
        $display("FAIL rw_vs_write: RegWrite=1 with MEMRead=1 in state %0d", state_out);
      end
    end
  end

  // --------------------------------------------------------------- drivers
  function automatic vec_t z(input logic [4:0] st);
    vec_t v;
    v    = '0;
    v.st = st;
    return v;
  endfunction

  task automatic push(input vec_t v, input string nm);
    exp_q.push_back(v);
    name_q.push_back(nm);
  endtask

  // Waits until the monitor has consumed every expected entry. Returns just
  // after the rising edge that follows the last comparison.
  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d entries left, required 0", exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

  task automatic do_reset(input int cycles);
    drain();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (dut_vec !== '0) begin
      errors++;
      $display("FAIL reset_immediate: got %h required 0", dut_vec);
    end
    for (int i = 0; i < cycles; i++) push(z(S_RESET), "reset_hold");
    drain();
    #2;
    reset = 1'b1;
    push(z(S_RESET), "reset_release");
  endtask

  // Sets the instruction inputs and queues FETCH, FETCH_WB and DECODE.
  task automatic start_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic ovf, input logic zr);
    vec_t v;
    drain();
    #2;
    OPCODE = op; funct = fn; Overflow = ovf; zero = zr;
    v = z(S_FETCH); v.srcb = 3'd1; v.aluc = 3'b001;
    for (int i = 0; i < MEM_WAIT; i++) push(v, "fetch");
    v = z(S_FETCH_WB); v.irw = 1; v.pcw = 1; v.srcb = 3'd1; v.aluc = 3'b001;
    push(v, "fetch_wb");
    v = z(S_DECODE); v.al = 1; v.bl = 1; v.srcb = 3'd3; v.aluc = 3'b001; v.aow = 1;
    push(v, "decode");
  endtask

  task automatic push_exc(input logic [2:0] vec_sel);
    vec_t v;
    v = z(S_EXC_EPC); v.srcb = 3'd1; v.aluc = 3'b010; v.aow = 1;
    push(v, "exc_epc");
    v = z(S_EXC_SAVE); v.epcw = 1; v.iord = vec_sel;
    push(v, "exc_save");
    v = z(S_EXC_READ); v.iord = vec_sel;
    for (int i = 0; i < MEM_WAIT - 1; i++) push(v, "exc_read");
    v = z(S_EXC_JUMP); v.lsc = 2'd2; v.pcs = 3'd4; v.pcw = 1;
    push(v, "exc_jump");
  endtask

  task automatic push_r_exec(input logic [2:0] op);
    vec_t v;
    v = z(S_R_EXEC); v.srca = 2'd1; v.aluc = op; v.aow = 1;
    push(v, "r_exec");
  endtask

  task automatic push_mem_addr();
    vec_t v;
    v = z(S_MEM_ADDR); v.srca = 2'd1; v.srcb = 3'd2; v.aluc = 3'b001; v.aow = 1;
    push(v, "mem_addr");
  endtask

  task automatic push_addi();
    vec_t v;
    v = z(S_ADDI); v.srca = 2'd1; v.srcb = 3'd2; v.aluc = 3'b001; v.aow = 1;
    push(v, "addi");
  endtask

  task automatic push_branch(input logic take);
    vec_t v;
    v = z(S_BRANCH); v.srca = 2'd1; v.aluc = 3'b010; v.pcs = 3'd1; v.pcw = take;
    push(v, "branch");
  endtask

  // ------------------------------------------------------------- stimulus
  initial begin
    vec_t v;
    reset = 1'b0; OPCODE = '0; funct = '0; Overflow = 1'b0; zero = 1'b0;
    @(posedge clk);
    do_reset(3);

    // add: 6 cycles, write rd from ALUOut
    start_instr(6'h00, 6'h20, 1'b0, 1'b0);
    push_r_exec(3'b001);
    v = z(S_R_WB); v.rdst = 2'd1; v.rw = 1; push(v, "add_wb");

    // slt with Overflow high: overflow ignored, comparator held in write-back
    start_instr(6'h00, 6'h2A, 1'b1, 1'b0);
    push_r_exec(3'b111);
    v = z(S_R_WB); v.rdst = 2'd1; v.rw = 1; v.m2r = 3'd1; v.srca = 2'd1; v.aluc = 3'b111;
    push(v, "slt_wb");

    // and
    start_instr(6'h00, 6'h24, 1'b0, 1'b0);
    push_r_exec(3'b011);
    v = z(S_R_WB); v.rdst = 2'd1; v.rw = 1; push(v, "and_wb");

    // beq taken / not taken, bne taken / not taken
    start_instr(6'h04, 6'h00, 1'b0, 1'b1); push_branch(1'b1);
    start_instr(6'h04, 6'h00, 1'b0, 1'b0); push_branch(1'b0);
    start_instr(6'h05, 6'h00, 1'b0, 1'b0); push_branch(1'b1);
    start_instr(6'h05, 6'h00, 1'b1, 1'b1); push_branch(1'b0);

    // lw: 8 cycles
    start_instr(6'h23, 6'h00, 1'b0, 1'b0);
    push_mem_addr();
    v = z(S_LW_READ); v.iord = 3'd3;
    for (int i = 0; i < MEM_WAIT; i++) push(v, "lw_read");
    v = z(S_LW_WB); v.mdr = 1; v.m2r = 3'd2; v.rw = 1; push(v, "lw_wb");

    // sw: single write cycle
    start_instr(6'h2B, 6'h00, 1'b0, 1'b0);
    push_mem_addr();
    v = z(S_SW_WRITE); v.iord = 3'd3; v.memr = 1; push(v, "sw_write");

    // j and jr
    start_instr(6'h02, 6'h00, 1'b0, 1'b0);
    v = z(S_J); v.pcw = 1; v.pcs = 3'd3; push(v, "j");
    start_instr(6'h00, 6'h08, 1'b0, 1'b0);
    v = z(S_JR); v.pcw = 1; v.pcs = 3'd5; push(v, "jr");

    // addi without overflow
    start_instr(6'h08, 6'h00, 1'b0, 1'b0);
    push_addi();
    v = z(S_ADDI_WB); v.rw = 1; push(v, "addi_wb");

    // invalid opcode -> vector 253
    start_instr(6'h3F, 6'h00, 1'b0, 1'b0);
    push_exc(3'd4);

    // addi overflow -> vector 254, no register write
    start_instr(6'h08, 6'h00, 1'b1, 1'b0);
    push_addi();
    push_exc(3'd5);

    // add overflow -> vector 254
    start_instr(6'h00, 6'h20, 1'b1, 1'b0);
    push_r_exec(3'b001);
    push_exc(3'd5);

    // invalid R funct right after an overflow: cause must return to 253
    start_instr(6'h00, 6'h3F, 1'b0, 1'b0);
    push_exc(3'd4);

    // reset pulled during LW_READ, then a clean add afterwards
    start_instr(6'h23, 6'h00, 1'b0, 1'b0);
    push_mem_addr();
    v = z(S_LW_READ); v.iord = 3'd3; push(v, "lw_read_pre_reset");
    do_reset(2);
    start_instr(6'h00, 6'h22, 1'b0, 1'b0);
    push_r_exec(3'b010);
    v = z(S_R_WB); v.rdst = 2'd1; v.rw = 1; push(v, "sub_wb");

    drain();
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
